// File: rtl/instr_encoder_if.sv
// Request/response bundle for instr_encoder.
// slave: the encoder side; master: the requester/consumer side.
interface instr_encoder_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_itype_i;
  logic [2:0]  req_funct3_i;
  logic [6:0]  req_funct7_i;
  logic [4:0]  req_rd_i;
  logic [4:0]  req_rs1_i;
  logic [4:0]  req_rs2_i;
  logic [11:0] req_imm_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [2:0]  count_o;
  logic        err_o;

  modport slave (
    input  req_valid_i, req_itype_i, req_funct3_i, req_funct7_i,
           req_rd_i, req_rs1_i, req_rs2_i, req_imm_i, instr_ready_i,
    output req_ready_o, instr_valid_o, instr_o, count_o, err_o
  );

  modport master (
    output req_valid_i, req_itype_i, req_funct3_i, req_funct7_i,
           req_rd_i, req_rs1_i, req_rs2_i, req_imm_i, instr_ready_i,
    input  req_ready_o, instr_valid_o, instr_o, count_o, err_o
  );
endinterface

// File: rtl/instr_encoder.sv
// instr_encoder: packs R-type / I-type ALU fields into RV32 words and
// queues them in a 4-entry FIFO (no bypass, one-cycle minimum latency).
// Optional macro ENC_FIELD_CHECK_EN: illegal funct7/funct3 combinations
// are accepted but dropped, with a one-cycle err_o pulse.
`ifndef Rtype_Opcode
`define Rtype_Opcode 7'b0110011
`endif
`ifndef Itype_Opcode
`define Itype_Opcode 7'b0010011
`endif

module instr_encoder (
  input  logic           clk_i,
  input  logic           rst_i,
  instr_encoder_if.slave bus
);
  logic [31:0] mem [4];
  logic [1:0]  wr_ptr, rd_ptr;
  logic [2:0]  count;
  logic [31:0] enc_word;
  logic        is_shift;
  logic        accept, push, pop;

  assign bus.req_ready_o   = (count < 3'd4);
  assign bus.instr_valid_o = (count != 3'd0);
  assign bus.instr_o       = mem[rd_ptr];
  assign bus.count_o       = count;

  assign accept = bus.req_valid_i && bus.req_ready_o;
  assign pop    = bus.instr_valid_o && bus.instr_ready_i;
  assign is_shift = bus.req_itype_i &&
                    (bus.req_funct3_i == 3'b001 || bus.req_funct3_i == 3'b101);

  // Field packing; shifts reuse funct7 in the upper bits and take shamt from imm[4:0]
  always_comb begin
    enc_word = {bus.req_funct7_i, bus.req_rs2_i, bus.req_rs1_i,
                bus.req_funct3_i, bus.req_rd_i, `Rtype_Opcode};
    if (is_shift)
      enc_word = {bus.req_funct7_i, bus.req_imm_i[4:0], bus.req_rs1_i,
                  bus.req_funct3_i, bus.req_rd_i, `Itype_Opcode};
    else if (bus.req_itype_i)
      enc_word = {bus.req_imm_i, bus.req_rs1_i,
                  bus.req_funct3_i, bus.req_rd_i, `Itype_Opcode};
  end

`ifdef ENC_FIELD_CHECK_EN
  logic illegal;
  logic err_q;

  // Legality of funct7/funct3; slli (001) needs funct7=0, srli/srai (101) allow 0 or 0100000
  always_comb begin
    illegal = 1'b0;
    if (!bus.req_itype_i) begin
      if (bus.req_funct7_i != 7'b0000000 && bus.req_funct7_i != 7'b0100000)
        illegal = 1'b1;
      else if (bus.req_funct7_i == 7'b0100000 &&
               bus.req_funct3_i != 3'b000 && bus.req_funct3_i != 3'b101)
        illegal = 1'b1;
    end else if (bus.req_funct3_i == 3'b001) begin
      illegal = (bus.req_funct7_i != 7'b0000000);
    end else if (bus.req_funct3_i == 3'b101) begin
      illegal = (bus.req_funct7_i != 7'b0000000 && bus.req_funct7_i != 7'b0100000);
    end
  end

  assign push = accept && !illegal;

  // Error pulse: high for the cycle after an illegal request is accepted
  always_ff @(posedge clk_i) begin
    if (!rst_i) err_q <= 1'b0;
    else        err_q <= accept && illegal;
  end

  assign bus.err_o = err_q;
`else
  assign push      = accept;
  assign bus.err_o = 1'b0;
`endif

  // Pointer and occupancy update; reset drops everything queued
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  // Storage write; data is left untouched by reset
  always_ff @(posedge clk_i) begin
    if (rst_i && push) mem[wr_ptr] <= enc_word;
  end
endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: the driver pushes expected words as
// requests are accepted; the monitor checks occupancy, handshake, err_o and
// each popped word against the queue.
module tb_instr_encoder;
  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  instr_encoder_if bus ();

  instr_encoder dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus));

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;
  logic [31:0] q[$];
  bit err_pend = 0;
  bit mon_en = 0;
  bit rand_rdy = 0;
  logic [31:0] cur_exp;
  bit cur_ill;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_enc(input bit it, input logic [2:0] f3,
      input logic [6:0] f7, input logic [4:0] rd, rs1, rs2, input logic [11:0] imm);
    logic [4:0] shamt;
    shamt = imm[4:0];
    if (!it) return {f7, rs2, rs1, f3, rd, 7'h33};
    if (f3 == 3'd1 || f3 == 3'd5) return {f7, shamt, rs1, f3, rd, 7'h13};
    return {imm, rs1, f3, rd, 7'h13};
  endfunction

  function automatic bit model_ill(input bit it, input logic [2:0] f3, input logic [6:0] f7);
`ifdef ENC_FIELD_CHECK_EN
    if (!it) return !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
    if (f3 == 3'd1) return f7 != 7'h00;
    if (f3 == 3'd5) return !(f7 == 7'h00 || f7 == 7'h20);
    return 1'b0;
`else
    return 1'b0 & it & f3[0] & f7[0];
`endif
  endfunction

  // Called at posedge+1; resolves this cycle's handshake just before the next edge
  task automatic tick(output bit acc);
    acc = 0;
    #8;
    if (!rst_i) begin
      q.delete();
      err_pend = 0;
    end else if (bus.req_valid_i && bus.req_ready_o) begin
      acc = 1;
      if (cur_ill) err_pend = 1;
      else q.push_back(cur_exp);
    end
    @(posedge clk_i);
    #1;
    if (rand_rdy) bus.instr_ready_i = ($urandom_range(0, 9) < 7);
  endtask

  task automatic set_fields(input bit it, input logic [2:0] f3, input logic [6:0] f7,
      input logic [4:0] rd, rs1, rs2, input logic [11:0] imm, input logic [31:0] exp);
    bus.req_itype_i = it; bus.req_funct3_i = f3; bus.req_funct7_i = f7;
    bus.req_rd_i = rd; bus.req_rs1_i = rs1; bus.req_rs2_i = rs2; bus.req_imm_i = imm;
    cur_exp = exp;
    cur_ill = model_ill(it, f3, f7);
  endtask

  task automatic scramble();
    bus.req_itype_i = 1'($urandom); bus.req_funct3_i = 3'($urandom);
    bus.req_funct7_i = 7'($urandom); bus.req_rd_i = 5'($urandom);
    bus.req_rs1_i = 5'($urandom); bus.req_rs2_i = 5'($urandom);
    bus.req_imm_i = 12'($urandom);
  endtask

  task automatic send(input bit it, input logic [2:0] f3, input logic [6:0] f7,
      input logic [4:0] rd, rs1, rs2, input logic [11:0] imm, input logic [31:0] exp);
    bit acc;
    int n;
    set_fields(it, f3, f7, rd, rs1, rs2, imm, exp);
    bus.req_valid_i = 1'b1;
    acc = 0;
    n = 0;
    while (!acc && n < 64) begin tick(acc); n++; end
    if (!acc) begin checks++; failures++; $display("FAIL accept_timeout act=0 exp=1"); end
    bus.req_valid_i = 1'b0;
    scramble();
  endtask

  task automatic idle(input int cycles);
    bit acc;
    for (int i = 0; i < cycles; i++) tick(acc);
  endtask

  task automatic drain();
    bit acc;
    int n;
    bus.instr_ready_i = 1'b1;
    n = 0;
    while ((q.size() != 0 || bus.instr_valid_o) && n < 64) begin tick(acc); n++; end
    chk("drain_empty", 32'(q.size()), 32'd0);
    idle(1);
  endtask

  // Monitor: mid-cycle compare of state against the scoreboard, then retire popped words
  initial begin
    forever begin
      @(negedge clk_i);
      if (mon_en) begin
        chk("count", 32'(bus.count_o), 32'(q.size()));
        chk("req_ready", 32'(bus.req_ready_o), 32'(q.size() < 4));
        chk("instr_valid", 32'(bus.instr_valid_o), 32'(q.size() != 0));
        chk("err", 32'(bus.err_o), 32'(err_pend));
        err_pend = 0;
        if (bus.instr_valid_o && q.size() != 0) begin
          chk("instr", bus.instr_o, q[0]);
          if (bus.instr_ready_i && rst_i) void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    bit acc;
    bus.req_valid_i = 1'b0;
    bus.instr_ready_i = 1'b0;
    scramble();
    cur_exp = '0;
    cur_ill = 0;
    @(posedge clk_i);
    #1;
    idle(2);
    rst_i = 1'b1;
    mon_en = 1;
    idle(1);

    // add x3,x1,x2 / addi x5,x0,-1 / srai x6,x7,3 with consumer ready
    bus.instr_ready_i = 1'b1;
    send(1'b0, 3'b000, 7'h00, 5'd3, 5'd1, 5'd2, 12'h000, 32'h002081B3);
    idle(2);
    send(1'b1, 3'b000, 7'h55, 5'd5, 5'd0, 5'd9, 12'hFFF, 32'hFFF00293);
    idle(2);
    send(1'b1, 3'b101, 7'h20, 5'd6, 5'd7, 5'd1, 12'hFE3, 32'h4033D313);
    idle(2);

    // R-type with funct7=1: dropped with err under field check, else encoded
    send(1'b0, 3'b000, 7'h01, 5'd3, 5'd1, 5'd2, 12'h000, 32'h022081B3);
    idle(2);

    // Fill to full, hold fifth, one pop-only cycle at full, then accept and drain
    bus.instr_ready_i = 1'b0;
    for (int i = 0; i < 4; i++)
      send(1'b0, 3'b000, 7'h00, 5'(i + 10), 5'd1, 5'd2, 12'h0, model_enc(1'b0, 3'b000, 7'h00, 5'(i + 10), 5'd1, 5'd2, 12'h0));
    set_fields(1'b1, 3'b100, 7'h00, 5'd20, 5'd4, 5'd0, 12'h123, model_enc(1'b1, 3'b100, 7'h00, 5'd20, 5'd4, 5'd0, 12'h123));
    bus.req_valid_i = 1'b1;
    tick(acc); chk("held_at_full", 32'(acc), 32'd0);
    bus.instr_ready_i = 1'b1;
    tick(acc); chk("no_push_on_full_pop", 32'(acc), 32'd0);
    bus.instr_ready_i = 1'b0;
    tick(acc); chk("fifth_accept", 32'(acc), 32'd1);
    bus.req_valid_i = 1'b0;
    drain();

    // Reset with two words queued and a request pending
    bus.instr_ready_i = 1'b0;
    send(1'b1, 3'b000, 7'h00, 5'd1, 5'd2, 5'd0, 12'h001, model_enc(1'b1, 3'b000, 7'h00, 5'd1, 5'd2, 5'd0, 12'h001));
    send(1'b1, 3'b000, 7'h00, 5'd3, 5'd4, 5'd0, 12'h002, model_enc(1'b1, 3'b000, 7'h00, 5'd3, 5'd4, 5'd0, 12'h002));
    set_fields(1'b0, 3'b000, 7'h00, 5'd9, 5'd9, 5'd9, 12'h0, 32'h0);
    bus.req_valid_i = 1'b1;
    rst_i = 1'b0;
    tick(acc);
    rst_i = 1'b1;
    bus.req_valid_i = 1'b0;
    bus.instr_ready_i = 1'b1;
    idle(3);

    // Random traffic with a randomly stalling consumer
    rand_rdy = 1;
    for (int i = 0; i < 300; i++) begin
      bit it;
      logic [2:0] f3;
      logic [6:0] f7;
      logic [4:0] rd, rs1, rs2;
      logic [11:0] imm;
      it = 1'($urandom);
      f3 = 3'($urandom);
      case ($urandom_range(0, 3))
        0: f7 = 7'h00;
        1: f7 = 7'h20;
        default: f7 = 7'($urandom);
      endcase
      rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom); imm = 12'($urandom);
      send(it, f3, f7, rd, rs1, rs2, imm, model_enc(it, f3, f7, rd, rs1, rs2, imm));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    rand_rdy = 0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
